// File: rtl/comparator_result_filter.sv
// comparator_result_filter
// Deglitches the greater/equal/less flags of a magnitude comparator.
// A result is published only after STABLE_COUNT consecutive identical legal
// samples; gaps (Enable_In=0) freeze the filter without breaking a run.
// Also counts entries into GT and LT and keeps a sticky illegal-sample flag.

module comparator_result_filter #(
  parameter int STABLE_COUNT = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Enable_In,
  input  logic                   A_gt_B_In,
  input  logic                   A_eq_B_In,
  input  logic                   A_lt_B_In,
  input  logic                   Clear_Counts_In,
  output logic                   Stable_Valid_Out,
  output logic [1:0]             Stable_Result_Out,
  output logic                   Result_Change_Out,
  output logic [COUNT_WIDTH-1:0] Gt_Count_Out,
  output logic [COUNT_WIDTH-1:0] Lt_Count_Out,
  output logic                   Error_Out
);

  localparam int RUN_W = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);
  localparam logic [RUN_W-1:0]       RUN_MAX = RUN_W'(STABLE_COUNT);
  localparam logic [RUN_W-1:0]       RUN_ONE = RUN_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_GT   = 2'b01;
  localparam logic [1:0] CODE_EQ   = 2'b10;
  localparam logic [1:0] CODE_LT   = 2'b11;

  typedef enum logic {EMPTY, STABLE} state_t;

  state_t           state;
  logic [1:0]       cand;
  logic [RUN_W-1:0] run;

  logic [1:0]       code;
  logic             legal;
  logic [1:0]       cand_next;
  logic [RUN_W-1:0] run_next;
  logic             sample;
  logic             accept;

  // One-hot decode; anything else (none, several, X/Z) is illegal.
  always_comb begin
    legal = 1'b0;
    code  = CODE_NONE;
    case ({A_gt_B_In, A_eq_B_In, A_lt_B_In})
      3'b100:  begin legal = 1'b1; code = CODE_GT; end
      3'b010:  begin legal = 1'b1; code = CODE_EQ; end
      3'b001:  begin legal = 1'b1; code = CODE_LT; end
      default: begin legal = 1'b0; code = CODE_NONE; end
    endcase
  end

  // Next candidate/run; acceptance looks at the run value this edge produces.
  always_comb begin
    sample    = Enable_In;
    cand_next = cand;
    run_next  = run;
    if (sample) begin
      if (!legal) begin
        cand_next = CODE_NONE;
        run_next  = '0;
      end else if (code == cand) begin
        run_next = (run == RUN_MAX) ? run : run + 1'b1;
      end else begin
        cand_next = code;
        run_next  = RUN_ONE;
      end
    end
    accept = sample && legal && (run_next == RUN_MAX) &&
             ((code != Stable_Result_Out) || (state == EMPTY));
  end

  // Run tracker state.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      cand <= CODE_NONE;
      run  <= '0;
    end else begin
      cand <= cand_next;
      run  <= run_next;
    end
  end

  // Published-result FSM: EMPTY until the first acceptance, then STABLE.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state             <= EMPTY;
      Stable_Valid_Out  <= 1'b0;
      Stable_Result_Out <= CODE_NONE;
      Result_Change_Out <= 1'b0;
    end else begin
      Result_Change_Out <= accept;
      case (state)
        EMPTY: begin
          if (accept) begin
            state             <= STABLE;
            Stable_Valid_Out  <= 1'b1;
            Stable_Result_Out <= code;
          end
        end
        STABLE: begin
          if (accept) Stable_Result_Out <= code;
        end
        default: begin
          state            <= EMPTY;
          Stable_Valid_Out <= 1'b0;
        end
      endcase
    end
  end

  // Saturating entry counters; clear wins over a same-edge increment.
  always_ff @(posedge Clock_In) begin
    if (Reset_In || Clear_Counts_In) begin
      Gt_Count_Out <= '0;
      Lt_Count_Out <= '0;
    end else if (accept) begin
      if (code == CODE_GT && Gt_Count_Out != CNT_MAX) Gt_Count_Out <= Gt_Count_Out + 1'b1;
      if (code == CODE_LT && Lt_Count_Out != CNT_MAX) Lt_Count_Out <= Lt_Count_Out + 1'b1;
    end
  end

  // Sticky illegal-sample flag; clear wins over a same-edge set.
  always_ff @(posedge Clock_In) begin
    if (Reset_In || Clear_Counts_In) Error_Out <= 1'b0;
    else if (sample && !legal)       Error_Out <= 1'b1;
  end

endmodule

// File: tb/tb_comparator_result_filter.sv
// Directed bench for comparator_result_filter. Each step pushes the expected
// post-edge outputs into a scoreboard queue and pops/compares them after the
// edge. A second instance with COUNT_WIDTH=2 shares the stimulus to check
// counter saturation.

module tb_comparator_result_filter;

  localparam logic [1:0] GT = 2'b01, EQ = 2'b10, LT = 2'b11;

  logic clk, rst, en, g, e, l, clr;
  logic       v,  ch,  er;
  logic [1:0] r;
  logic [7:0] gc, lc;
  logic       v2, ch2, er2;
  logic [1:0] r2, gc2, lc2;

  typedef struct {
    string      tag;
    logic       v, ch, er;
    logic [1:0] r, gc2, lc2;
    logic [7:0] gc, lc;
  } exp_t;
  exp_t sb[$];

  logic       e_v, e_er;
  logic [1:0] e_r, e_gc2, e_lc2;
  logic [7:0] e_gc, e_lc;
  int checks = 0, fails = 0;

  comparator_result_filter #(.STABLE_COUNT(4), .COUNT_WIDTH(8)) dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
    .A_gt_B_In(g), .A_eq_B_In(e), .A_lt_B_In(l), .Clear_Counts_In(clr),
    .Stable_Valid_Out(v), .Stable_Result_Out(r), .Result_Change_Out(ch),
    .Gt_Count_Out(gc), .Lt_Count_Out(lc), .Error_Out(er));

  comparator_result_filter #(.STABLE_COUNT(4), .COUNT_WIDTH(2)) dut_sat (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
    .A_gt_B_In(g), .A_eq_B_In(e), .A_lt_B_In(l), .Clear_Counts_In(clr),
    .Stable_Valid_Out(v2), .Stable_Result_Out(r2), .Result_Change_Out(ch2),
    .Gt_Count_Out(gc2), .Lt_Count_Out(lc2), .Error_Out(er2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge, compare outputs at the next negedge.
  task automatic step(input logic i_en, i_g, i_e, i_l, i_clr, i_rst,
                      input logic x_ch, input string tag);
    exp_t x;
    en = i_en; g = i_g; e = i_e; l = i_l; clr = i_clr; rst = i_rst;
    x.tag = tag; x.v = e_v; x.r = e_r; x.ch = x_ch; x.er = e_er;
    x.gc = e_gc; x.lc = e_lc; x.gc2 = e_gc2; x.lc2 = e_lc2;
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    chk({x.tag, ":valid"},  v,   x.v);
    chk({x.tag, ":result"}, r,   x.r);
    chk({x.tag, ":change"}, ch,  x.ch);
    chk({x.tag, ":gt_cnt"}, gc,  x.gc);
    chk({x.tag, ":lt_cnt"}, lc,  x.lc);
    chk({x.tag, ":error"},  er,  x.er);
    chk({x.tag, ":w2_res"}, {5'b0, v2, r2}, {5'b0, x.v, x.r});
    chk({x.tag, ":w2_chg"}, {6'b0, ch2, er2}, {6'b0, x.ch, x.er});
    chk({x.tag, ":w2_gt"},  gc2, x.gc2);
    chk({x.tag, ":w2_lt"},  lc2, x.lc2);
  endtask

  task automatic smp(input logic [1:0] c, input logic x_ch, input string tag);
    step(1'b1, c == GT, c == EQ, c == LT, 1'b0, 1'b0, x_ch, tag);
  endtask

  task automatic gap(input int n, input string tag);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic zero_exp();
    e_v = 0; e_r = 0; e_er = 0; e_gc = 0; e_lc = 0; e_gc2 = 0; e_lc2 = 0;
  endtask

  task automatic clr_exp();
    e_er = 0; e_gc = 0; e_lc = 0; e_gc2 = 0; e_lc2 = 0;
  endtask

  // Expected effect of an acceptance of code c.
  task automatic acc(input logic [1:0] c);
    e_v = 1'b1; e_r = c;
    if (c == GT) begin
      if (e_gc != 8'hFF) e_gc++;
      if (e_gc2 != 2'd3) e_gc2++;
    end
    if (c == LT) begin
      if (e_lc != 8'hFF) e_lc++;
      if (e_lc2 != 2'd3) e_lc2++;
    end
  endtask

  initial begin
    en = 0; g = 0; e = 0; l = 0; clr = 0; rst = 1;
    zero_exp();
    step(0, 0, 0, 0, 0, 1, 0, "reset");
    step(0, 0, 0, 0, 0, 1, 0, "reset2");

    // GT held four samples: accepted on the 4th, pulse for one cycle.
    repeat (3) smp(GT, 0, "t1_fill");
    acc(GT); smp(GT, 1, "t1_accept");
    gap(1, "t1_pulse_end");

    // A single LT glitch restarts the run.
    zero_exp(); step(0, 0, 0, 0, 0, 1, 0, "t2_reset");
    repeat (3) smp(GT, 0, "t2_gt");
    smp(LT, 0, "t2_glitch");
    repeat (3) smp(GT, 0, "t2_refill");
    acc(GT); smp(GT, 1, "t2_accept");

    // Switch to LT across an enable gap.
    repeat (3) smp(LT, 0, "t3_lt");
    gap(5, "t3_gap");
    acc(LT); smp(LT, 1, "t3_accept");

    // Illegal GT+LT sample: sticky error, run restarts.
    smp(GT, 0, "t4_gt"); smp(GT, 0, "t4_gt");
    e_er = 1; step(1, 1, 0, 1, 0, 0, 0, "t4_bad");
    gap(2, "t4_sticky");
    repeat (3) smp(GT, 0, "t4_refill");
    acc(GT); smp(GT, 1, "t4_accept");
    smp(GT, 0, "t4_hold_same");

    // Clear pulse keeps the stable result.
    clr_exp(); step(0, 0, 0, 0, 1, 0, 0, "t5_clear");

    // No flag set is illegal too.
    e_er = 1; step(1, 0, 0, 0, 0, 0, 0, "t5_zero_flags");

    // Illegal sample together with clear: error ends 0, run still cleared.
    repeat (3) smp(LT, 0, "t6_lt");
    e_er = 0; step(1, 1, 1, 0, 1, 0, 0, "t6_bad_clr");
    repeat (3) smp(LT, 0, "t6_refill");
    acc(LT); smp(LT, 1, "t6_accept");

    // Clear beats the increment from a same-edge GT acceptance.
    repeat (3) smp(GT, 0, "t7_gt");
    e_r = GT; clr_exp(); step(1, 1, 0, 0, 1, 0, 1, "t7_accept_clr");

    // Five GT entries: 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      repeat (3) smp(EQ, 0, "t8_eq");
      acc(EQ); smp(EQ, 1, "t8_eq_acc");
      repeat (3) smp(GT, 0, "t8_gt");
      acc(GT); smp(GT, 1, "t8_gt_acc");
    end

    // Reset mid-run (with a sample present) discards the partial run.
    zero_exp(); step(1, 1, 0, 0, 0, 1, 0, "t9_reset");
    smp(GT, 0, "t9_gt"); smp(GT, 0, "t9_gt");
    step(1, 1, 0, 0, 0, 1, 0, "t9_reset_mid");
    smp(GT, 0, "t9_fresh"); smp(GT, 0, "t9_fresh"); smp(GT, 0, "t9_fresh");
    acc(GT); smp(GT, 1, "t9_accept");
    gap(1, "t9_end");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/comparator_result_filter.md
Name: comparator_result_filter

Overview:
- Downstream consumer of the 4-bit magnitude comparator's three result flags (greater / equal / less).
- Qualifies the flags with the comparator enable and rejects glitches: a result is accepted only after STABLE_COUNT consecutive identical valid samples.
- Publishes a registered stable result with a change pulse, counts entries into the GT and LT states, and flags illegal flag combinations.
- Feeds threshold/alarm logic that must not react to single-cycle comparator transients.

Parameters:
- STABLE_COUNT, 4: consecutive identical valid samples needed to accept a result; legal range 1..255.
- COUNT_WIDTH, 8: width of the GT/LT event counters.

Ports:
- Clock_In  input  1  rising-edge clock.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  comparator enable; flags are sampled only when 1, and are Z when 0.
- A_gt_B_In  input  1  comparator greater-than flag.
- A_eq_B_In  input  1  comparator equal flag.
- A_lt_B_In  input  1  comparator less-than flag.
- Clear_Counts_In  input  1  synchronous clear of event counters and error flag.
- Stable_Valid_Out  output  1  high once any result has been accepted.
- Stable_Result_Out  output  2  accepted result: 00 none, 01 GT, 10 EQ, 11 LT.
- Result_Change_Out  output  1  one-cycle pulse when Stable_Result_Out changes.
- Gt_Count_Out  output  COUNT_WIDTH  number of transitions into stable GT, saturating.
- Lt_Count_Out  output  COUNT_WIDTH  number of transitions into stable LT, saturating.
- Error_Out  output  1  sticky illegal-sample flag.

Behaviour:
- Reset (Reset_In=1 at a rising edge): every output and internal register goes to 0. This gives Stable_Valid_Out=0 and Stable_Result_Out=00. The FSM returns to EMPTY, candidate=00, run=0. Reset has priority over all other inputs, including mid-run.
- Sampling:
  - A sample occurs only in cycles with Enable_In=1.
  - Enable_In=0 holds all state; a gap does not break a run.
- Decode: exactly one flag high gives code 01/10/11. Zero or more than one flag high (X/Z included) is an illegal sample. An illegal sample:
  - sets Error_Out,
  - clears the run counter and candidate to 00,
  - leaves the stable result unchanged.
- Run tracking on a legal sample:
  - If the code equals the candidate, run increments, saturating at STABLE_COUNT.
  - Otherwise candidate <= code and run <= 1.
  - Run counter width is clog2(STABLE_COUNT+1).
- Acceptance:
  - Condition: on the edge where the next run value equals STABLE_COUNT and the candidate code differs from Stable_Result_Out (or the FSM is in EMPTY).
  - On that same edge: Stable_Result_Out <= code, Stable_Valid_Out <= 1, Result_Change_Out <= 1 for that one cycle.
  - Result_Change_Out is 0 in every other cycle.
  - Re-accepting the same code produces no pulse and no count.
- Latency: samples in cycles t..t+STABLE_COUNT-1 produce the new result visible in cycle t+STABLE_COUNT. With STABLE_COUNT=1 the output follows each legal sample one cycle later.
- FSM:
  - EMPTY: Stable_Valid_Out=0. Moves to STABLE on the first acceptance.
  - STABLE: leaves only on reset.
- Counters:
  - Gt_Count_Out increments on each acceptance of 01; Lt_Count_Out on each acceptance of 11. EQ is not counted.
  - Counters saturate at 2^COUNT_WIDTH-1 and do not wrap.
- Clear_Counts_In=1: zeroes both counters and Error_Out on that edge. Clear beats a simultaneous increment or error set. It does not touch the stable result, candidate or run.
- Simultaneous illegal sample and Clear_Counts_In: Error_Out ends 0, run cleared.

Test Plan:
- Reset, then Enable_In=1 with GT held 4 cycles (STABLE_COUNT=4) -> Stable_Result_Out=01 and Stable_Valid_Out=1 in cycle 5; Result_Change_Out high exactly in cycle 5; Gt_Count_Out=1.
- GT,GT,GT,LT,GT,GT,GT,GT -> no acceptance until the 8th sample; one change pulse; Lt_Count_Out=0.
- Stable GT, then LT x3, Enable_In=0 for 5 cycles, LT x1 -> switch to 11 after the 4th LT sample; the gap is ignored; Lt_Count_Out=1.
- Sample with GT=1 and LT=1 -> Error_Out=1 next cycle and stays set; run restarts. Clear_Counts_In pulse -> Error_Out=0 and counters=0, Stable_Result_Out unchanged.
- COUNT_WIDTH=2, alternate 4xGT / 4xEQ for 5 GT entries -> Gt_Count_Out saturates at 3.
- Assert Reset_In after 2 of 4 GT samples, then 2 more GT samples -> no acceptance; Stable_Valid_Out stays 0 until 4 fresh GT samples.
